i2c_slave_phy: RTL

Bit-level I2C slave engine that sits directly below the slave register driver. It oversamples SCL/SDA with the system clock, detects START/STOP, matches the 7-bit device address, shifts bytes in and out, and handles ACK. It hands bytes upward on datareceive/received and fetches outgoing bytes from datasend, pulsing sended after each transmitted byte. No clock stretching.

---
 rtl/i2c_slave_phy.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_phy.sv
// I2C slave bit engine: input filtering, START/STOP detection,
// address match, byte shifting and ACK handling.
module i2c_slave_phy #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] address,
  input  logic [7:0] datasend,
  output logic       sended,
  output logic [7:0] datareceive,
  output logic       received,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA,
    RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sr, sr_n;
  logic [7:0] drx_n;
  logic rw, rw_n, full, full_n, nack, nack_n;
  logic oe_n, snd_n, rcv_n, bsy_n;

  // Filtered level only moves once the whole history agrees
  always_comb begin
    scl_f = (&scl_hist) ? 1'b1 : (~|scl_hist) ? 1'b0 : scl_d;
    sda_f = (&sda_hist) ? 1'b1 : (~|sda_hist) ? 1'b0 : sda_d;
    scl_rise = scl_f & ~scl_d;
    scl_fall = ~scl_f & scl_d;
    start = scl_f & scl_d & sda_d & ~sda_f;
    stop = scl_f & scl_d & ~sda_d & sda_f;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      rw <= 1'b0;
      full <= 1'b0;
      nack <= 1'b0;
      sda_oe <= 1'b0;
      sended <= 1'b0;
      received <= 1'b0;
      datareceive <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      rw <= rw_n;
      full <= full_n;
      nack <= nack_n;
      sda_oe <= oe_n;
      sended <= snd_n;
      received <= rcv_n;
      datareceive <= drx_n;
      busy <= bsy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    rw_n = rw;
    full_n = full;
    nack_n = nack;
    oe_n = sda_oe;
    snd_n = sended;
    rcv_n = received;
    drx_n = datareceive;
    bsy_n = busy;
    if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      full_n = 1'b0;
      bsy_n = 1'b1;
      oe_n = 1'b0;
      rcv_n = 1'b0;
      snd_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      bsy_n = 1'b0;
      oe_n = 1'b0;
      rcv_n = 1'b0;
      snd_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            sr_n = {sr[6:0], sda_f};
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (sr[6:0] == address) begin
                state_n = ADDR_ACK;
                rw_n = sda_f;
              end else begin
                state_n = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          // First fall starts the ACK, second fall ends it
          if (scl_fall) begin
            cnt_n = '0;
            if (!sda_oe) begin
              oe_n = 1'b1;
            end else if (rw) begin
              sr_n = datasend;
              oe_n = ~datasend[7];
              state_n = TX_DATA;
            end else begin
              oe_n = 1'b0;
              full_n = 1'b0;
              state_n = RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (scl_rise) begin
            sr_n = {sr[6:0], sda_f};
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) full_n = 1'b1;
          end else if (scl_fall && full) begin
            drx_n = sr;
            rcv_n = 1'b1;
            oe_n = 1'b1;
            full_n = 1'b0;
            state_n = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            oe_n = 1'b0;
            rcv_n = 1'b0;
            cnt_n = '0;
            state_n = RX_DATA;
          end
        end
        TX_DATA: begin
          if (scl_fall) begin
            if (cnt == 3'd7) begin
              oe_n = 1'b0;
              state_n = TX_ACK;
            end else begin
              sr_n = {sr[6:0], 1'b0};
              oe_n = ~sr[6];
              cnt_n = cnt + 3'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            snd_n = 1'b1;
            nack_n = sda_f;
          end else if (scl_fall && sended) begin
            snd_n = 1'b0;
            cnt_n = '0;
            if (!nack) begin
              sr_n = datasend;
              oe_n = ~datasend[7];
              state_n = TX_DATA;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: oe_n = 1'b0;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
